// File: rtl/aes_state_demux.sv
// aes_state_demux: collects a serial byte stream into a 16-byte AES state
// block (byte 0 in the top lane). It holds the finished block under
// backpressure, and can overlap delivery of one block with the first byte
// of the next.
module aes_state_demux #(
  parameter bit INVERT = 1'b1,  // undo the inverting selector upstream
  parameter int BYTES  = 16     // only 16 is meaningful; fill counter is 4 bits
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         i_in_data,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic               i_flush,
  output logic [8*BYTES-1:0] o_out_block,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [3:0]         o_fill_cnt
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_fill_cnt, w_fill_cnt_nxt;
  logic [BYTES-1:0][7:0] r_lane;   // r_lane[BYTES-1] is byte 0
  logic                  w_cap;
  logic [7:0]            w_byte;

  // In FULL a byte can only enter when the held block leaves on the same edge.
  assign o_in_ready  = (r_state == FILL) | ((r_state == FULL) & i_out_ready & ~i_flush);
  // A flush in FILL still shows ready, but the offered byte is dropped.
  assign w_cap       = i_in_valid & o_in_ready & ~i_flush;
  assign w_byte      = i_in_data ^ {8{INVERT}};
  assign o_out_valid = (r_state == FULL);
  assign o_out_block = r_lane;
  assign o_fill_cnt  = r_fill_cnt;

  // Next state and fill count; flush wins over everything else.
  always_comb begin
    w_state_nxt    = r_state;
    w_fill_cnt_nxt = r_fill_cnt;
    case (r_state)
      FILL: begin
        if (i_flush) begin
          w_fill_cnt_nxt = 4'd0;
        end else if (w_cap) begin
          // Counter wraps 15 -> 0 exactly as the block completes.
          w_fill_cnt_nxt = r_fill_cnt + 4'd1;
          if (r_fill_cnt == 4'(BYTES - 1)) w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (i_flush) begin
          w_state_nxt    = FILL;
          w_fill_cnt_nxt = 4'd0;
        end else if (i_out_ready) begin
          // Zero-bubble handoff: a byte taken on the delivery edge lands in lane 0.
          w_state_nxt    = FILL;
          w_fill_cnt_nxt = w_cap ? 4'd1 : 4'd0;
        end
      end
      default: begin
        w_state_nxt    = FILL;
        w_fill_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_fill_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_cnt_nxt;
    end
  end

  // Lane capture: only the lane addressed by the fill count is written.
  // In FULL the count is 0, so an overlapped byte goes to lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
    end else if (w_cap) begin
      for (int i = 0; i < BYTES; i++) begin
        if (r_fill_cnt == 4'(i)) r_lane[BYTES-1-i] <= w_byte;
      end
    end
  end

endmodule

// File: doc/aes_state_demux.md
AES_STATE_DEMUX -- requirements
Module: aes_state_demux

Interface
REQ-001 Parameter INVERT, default 1: when 1, every input byte is bit-inverted on capture; this compensates the inverting selector stage upstream.
REQ-002 Parameter BYTES, default 16: number of bytes per block; the only legal value is 16, and the output width is 8*BYTES.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 in_data  input  8: serial byte stream, first byte = AES state byte 0 (column-major order).
REQ-006 in_valid  input  1: in_data is valid this cycle.
REQ-007 in_ready  output  1: the block accepts in_data this cycle.
REQ-008 flush  input  1: synchronous abort; discards the partial block.
REQ-009 out_block  output  128: assembled block, byte 0 at [127:120], byte 15 at [7:0].
REQ-010 out_valid  output  1: out_block holds a complete block.
REQ-011 out_ready  input  1: the consumer takes out_block this cycle.
REQ-012 fill_cnt  output  4: number of bytes captured into the current partial block (0-15).

Function
REQ-013 State machine, FILL and FULL, with the following rules:
- FILL: collecting bytes; out_valid=0.
- FULL: block complete; out_valid=1.
REQ-014 A byte is accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-015 Byte capture: an accepted byte is written to lane fill_cnt, i.e. out_block[127-8*fill_cnt -: 8], as in_data^{8{INVERT}}; fill_cnt then increments.
REQ-016 Other lanes: lanes not being written hold their value; no other lane changes on a capture.
REQ-017 FILL to FULL: when the byte is accepted at fill_cnt=15, fill_cnt wraps to 0 and the state moves to FULL on the same edge, so out_valid rises 1 cycle after the 16th byte.
REQ-018 Output handshake: in FULL, a block is delivered when out_valid and out_ready are both 1 at a rising edge.
REQ-019 FULL without new byte: if a block is delivered with no simultaneous accepted byte, the next state is FILL.
REQ-020 in_ready = (state==FILL) | (state==FULL & out_ready & ~flush); this is a combinational function of state, out_ready and flush.
REQ-021 Simultaneous delivery and capture: in FULL, when a block is delivered and a byte is accepted on the same edge, the byte goes to lane 0 and the state becomes FILL with fill_cnt=1, giving zero bubble between blocks.
REQ-022 out_block stability: out_block is stable while out_valid=1 and out_ready=0; in_ready is 0 in that condition (backpressure).
REQ-023 Stale lanes: lanes not yet rewritten during FILL keep stale data; out_block is don't-care while out_valid=0.
REQ-024 flush in FILL: the next state is FILL and fill_cnt=0; the byte offered on that cycle is dropped.
REQ-025 flush in FULL: flush has priority over out_ready; the block is discarded (counts as not delivered), the next state is FILL, fill_cnt=0 and in_ready=0 that cycle.
REQ-026 Latency: the first byte in to out_valid is 16 accepted bytes plus 1 cycle; out_valid asserts only once per block.

Reset
REQ-027 While rst_n=0, the outputs are forced immediately regardless of clk:
- state FILL;
- fill_cnt=0;
- out_valid=0;
- out_block=128'h0.
REQ-028 Reset released with in_valid=1: in_ready=1 from the first cycle after release, and the first accepted byte goes to lane 0.
REQ-029 Reset mid-block or while FULL: the partial or complete block is discarded and never presented.

Verification
REQ-030 INVERT=0, 16 consecutive bytes 8'h00..8'h0F, out_ready=1 -> out_valid=1 for one cycle, 1 cycle after the last byte, with out_block=128'h000102030405060708090A0B0C0D0E0F.
REQ-031 INVERT=1, 16 bytes all 8'hFF -> out_block=128'h0; a second block of 16 bytes 8'h5A -> out_block = 16 repeats of 8'hA5.
REQ-032 Block complete with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0, out_block unchanged and fill_cnt=0 for 5 cycles; then out_ready=1 -> delivery and lane-0 capture on the same edge, fill_cnt=1.
REQ-033 flush asserted at fill_cnt=7 -> fill_cnt=0 next cycle; the following 16 bytes form a clean block and out_valid asserts only after all 16.
REQ-034 rst_n pulsed low asynchronously at fill_cnt=9, and separately while FULL -> out_valid=0 and fill_cnt=0 immediately; no stale block is output after release.
REQ-035 Random in_valid/out_ready (50%) over 1000 blocks -> the scoreboard matches every block in order, with no loss or duplication.
